muldiv_hilo_sequencer: RTL and testbench

Iterative multiply/divide controller that owns the HI/LO write port of the register file.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage.
- Sequences a multi-cycle shift-add multiply or restoring divide.
- Drives HI_write_enable/LO_write_enable and HI_write_data/LO_write_data.
- Stalls the pipeline while an MFHI/MFLO, or a new command, would see stale HI/LO.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_hilo_sequencer_if.sv | 28 ++
 rtl/muldiv_iter_step.sv | 36 +++
 rtl/muldiv_hilo_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_hilo_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        WRITE = 2'd3
    } muldiv_state_t;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_hilo_sequencer_if.sv
// Execute-stage command / HI-LO write-port bundle for the muldiv sequencer.
interface muldiv_hilo_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             read_hilo_request;
    logic             busy;
    logic             stall;
    logic             HI_write_enable;
    logic             LO_write_enable;
    logic [WIDTH-1:0] HI_write_data;
    logic [WIDTH-1:0] LO_write_data;

    modport master (
        output start, op, operand_a, operand_b, read_hilo_request,
        input  busy, stall, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
    );

    modport slave (
        input  start, op, operand_a, operand_b, read_hilo_request,
        output busy, stall, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] addend_i,
    input  logic [WIDTH-1:0]   bits_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] addend_o,
    output logic [WIDTH-1:0]   bits_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Divide: acc low half is the partial remainder, bits holds dividend/quotient.
    // Since remainder < divisor, diff[WIDTH] is a reliable borrow flag.
    always_comb begin
        shifted = {acc_i[WIDTH-1:0], bits_i[WIDTH-1]};
        diff    = shifted - {1'b0, addend_i[WIDTH-1:0]};
        if (is_div_i) begin
            addend_o = addend_i;
            if (!diff[WIDTH]) begin
                acc_o  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                bits_o = {bits_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o  = {{WIDTH{1'b0}}, shifted[WIDTH-1:0]};
                bits_o = {bits_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o    = bits_i[0] ? (acc_i + addend_i) : acc_i;
            addend_o = addend_i << 1;
            bits_o   = bits_i >> 1;
        end
    end
endmodule

// File: rtl/muldiv_hilo_sequencer.sv
// Iterative MULT/DIV sequencer owning the HI/LO write port; stalls stale HI/LO readers.
// Optional MULDIV_EARLY_TERM_EN: finish a multiply as soon as the remaining multiplier is zero.
module muldiv_hilo_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    muldiv_hilo_sequencer_if.slave hilo_bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int W2    = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d, addend_q, addend_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
    logic             hi_we_q, hi_we_d, lo_we_q, lo_we_d;
    logic [WIDTH-1:0] hi_data_q, hi_data_d, lo_data_q, lo_data_d;
    logic             op_signed, last_iter, busy;
    logic [W2-1:0]    product;

    logic [W2-1:0]    acc_chain    [BITS_PER_CYCLE+1];
    logic [W2-1:0]    addend_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] bits_chain   [BITS_PER_CYCLE+1];

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [W2-1:0] negate_wide_if(input logic [W2-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign acc_chain[0]    = acc_q;
    assign addend_chain[0] = addend_q;
    assign bits_chain[0]   = bits_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
            .is_div_i (state_q == DIV),
            .acc_i    (acc_chain[g]),
            .addend_i (addend_chain[g]),
            .bits_i   (bits_chain[g]),
            .acc_o    (acc_chain[g+1]),
            .addend_o (addend_chain[g+1]),
            .bits_o   (bits_chain[g+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        addend_d  = addend_q;
        bits_d    = bits_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_we_d   = 1'b0;
        lo_we_d   = 1'b0;
        hi_data_d = hi_data_q;
        lo_data_d = lo_data_q;
        op_signed = (hilo_bus.op == OP_MULT) || (hilo_bus.op == OP_DIV);
        product   = negate_wide_if(acc_chain[BITS_PER_CYCLE], quo_neg_q);
`ifdef MULDIV_EARLY_TERM_EN
        last_iter = (cnt_q == CNT_W'(1)) ||
                    ((state_q == MUL) && (bits_chain[BITS_PER_CYCLE] == '0));
`else
        last_iter = (cnt_q == CNT_W'(1));
`endif

        unique case (state_q)
            IDLE: begin
                if (hilo_bus.start) begin
                    case (hilo_bus.op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = '0;
                            addend_d  = {{WIDTH{1'b0}}, magnitude(hilo_bus.operand_a, op_signed)};
                            bits_d    = magnitude(hilo_bus.operand_b, op_signed);
                            quo_neg_d = op_signed & (hilo_bus.operand_a[WIDTH-1] ^ hilo_bus.operand_b[WIDTH-1]);
                            cnt_d     = CNT_W'(N);
                            state_d   = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d     = '0;
                            addend_d  = {{WIDTH{1'b0}}, magnitude(hilo_bus.operand_b, op_signed)};
                            bits_d    = magnitude(hilo_bus.operand_a, op_signed);
                            quo_neg_d = op_signed & (hilo_bus.operand_a[WIDTH-1] ^ hilo_bus.operand_b[WIDTH-1]);
                            rem_neg_d = op_signed & hilo_bus.operand_a[WIDTH-1];
                            div0_d    = (hilo_bus.operand_b == '0);
                            cnt_d     = CNT_W'(N);
                            state_d   = DIV;
                        end
                        OP_MTHI: begin
                            hi_we_d   = 1'b1;
                            hi_data_d = hilo_bus.operand_a;
                        end
                        OP_MTLO: begin
                            lo_we_d   = 1'b1;
                            lo_data_d = hilo_bus.operand_a;
                        end
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                acc_d    = acc_chain[BITS_PER_CYCLE];
                addend_d = addend_chain[BITS_PER_CYCLE];
                bits_d   = bits_chain[BITS_PER_CYCLE];
                cnt_d    = cnt_q - CNT_W'(1);
                // Sign fix-up happens as the final result is captured, so WRITE only strobes.
                if (last_iter) begin
                    state_d = WRITE;
                    hi_we_d = 1'b1;
                    lo_we_d = 1'b1;
                    if (state_q == MUL) begin
                        {hi_data_d, lo_data_d} = product;
                    end else begin
                        hi_data_d = negate_if(acc_chain[BITS_PER_CYCLE][WIDTH-1:0], rem_neg_q);
                        lo_data_d = div0_q ? WIDTH'(DIV0_QUOTIENT)
                                           : negate_if(bits_chain[BITS_PER_CYCLE], quo_neg_q);
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_we_q   <= 1'b0;
            lo_we_q   <= 1'b0;
            hi_data_q <= '0;
            lo_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_we_q   <= hi_we_d;
            lo_we_q   <= lo_we_d;
            hi_data_q <= hi_data_d;
            lo_data_q <= lo_data_d;
        end
    end

    // Iteration datapath is always reloaded on command accept, so it needs no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        addend_q <= addend_d;
        bits_q   <= bits_d;
    end

    assign busy                     = (state_q != IDLE);
    assign hilo_bus.busy            = busy;
    assign hilo_bus.stall           = busy & (hilo_bus.start | hilo_bus.read_hilo_request);
    assign hilo_bus.HI_write_enable = hi_we_q;
    assign hilo_bus.LO_write_enable = lo_we_q;
    assign hilo_bus.HI_write_data   = hi_data_q;
    assign hilo_bus.LO_write_data   = lo_data_q;
endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Scoreboard bench for muldiv_hilo_sequencer: expected HI/LO writes queued at issue, checked on strobe.
module tb_muldiv_hilo_sequencer;
    import muldiv_pkg::*;

    localparam int LAT = 33;

    typedef struct {
        logic        hw;
        logic        lw;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   n_writes;
    exp_t sb_q[$];

    muldiv_hilo_sequencer_if #(.WIDTH(32)) hilo ();

    muldiv_hilo_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .hilo_bus (hilo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input muldiv_op_t op, input logic [31:0] a,
                                   input logic [31:0] b, input int c0);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        e.hw  = 1'b1;
        e.lw  = 1'b1;
        e.hi  = '0;
        e.lo  = '0;
        e.cyc = c0 + LAT;
        sa    = a;
        sb    = b;
        case (op)
            OP_MULT: begin
                sp   = longint'(sa) * longint'(sb);
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            OP_MULTU: begin
                up   = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            OP_MTHI: begin
                e.lw  = 1'b0;
                e.hi  = a;
                e.cyc = c0 + 1;
            end
            OP_MTLO: begin
                e.hw  = 1'b0;
                e.lo  = a;
                e.cyc = c0 + 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (hilo.HI_write_enable || hilo.LO_write_enable) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'({hilo.HI_write_enable, hilo.LO_write_enable}), 64'(2'b00));
            end else begin
                e = sb_q.pop_front();
                check("write_enables", 64'({hilo.HI_write_enable, hilo.LO_write_enable}), 64'({e.hw, e.lw}));
                if (e.hw) check("hi_data", 64'(hilo.HI_write_data), 64'(e.hi));
                if (e.lw) check("lo_data", 64'(hilo.LO_write_data), 64'(e.lo));
                check("write_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_result);
        @(posedge clk); #1;
        hilo.start     = 1'b1;
        hilo.op        = op;
        hilo.operand_a = a;
        hilo.operand_b = b;
        if (expect_result) sb_q.push_back(model(op, a, b, cyc));
        @(posedge clk); #1;
        hilo.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (hilo.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (hilo.busy) check("idle_timeout", 64'(hilo.busy), 64'(1'b0));
    endtask

    initial begin
        int          c0;
        int          w0;
        muldiv_op_t  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        n_checks = 0;
        n_errors = 0;
        n_writes = 0;
        reset = 1'b1;
        hilo.start = 1'b0;
        hilo.op = OP_MULT;
        hilo.operand_a = '0;
        hilo.operand_b = '0;
        hilo.read_hilo_request = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(hilo.busy), 64'(0));
        check("rst_stall", 64'(hilo.stall), 64'(0));
        check("rst_hi_we", 64'(hilo.HI_write_enable), 64'(0));
        check("rst_lo_we", 64'(hilo.LO_write_enable), 64'(0));
        check("rst_hi_data", 64'(hilo.HI_write_data), 64'(0));
        check("rst_lo_data", 64'(hilo.LO_write_data), 64'(0));
        reset = 1'b0;

        // Signed multiply with exact latency and busy window
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        c0 = cyc - 1;
        check("mult_busy_c1", 64'(hilo.busy), 64'(1));
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("mult_busy_c33", 64'(hilo.busy), 64'(1));
        check("mult_we_c33", 64'({hilo.HI_write_enable, hilo.LO_write_enable}), 64'(2'b11));
        @(posedge clk); #1;
        check("mult_busy_c34", 64'(hilo.busy), 64'(0));
        check("mult_we_c34", 64'({hilo.HI_write_enable, hilo.LO_write_enable}), 64'(2'b00));
        check("mult_hold_lo", 64'(hilo.LO_write_data), 64'(32'hFFFF_FFEB));

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,          1'b1); wait_idle();
        issue(OP_DIVU,  32'd7,         32'd0,          1'b1); wait_idle();
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  1'b1); wait_idle();
        issue(OP_DIV,   32'hFFFF_FF00, 32'd0,          1'b1); wait_idle();
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000,  1'b1); wait_idle();

        issue(OP_MTHI, 32'h1234_5678, 32'd0, 1'b1);
        check("mthi_busy", 64'(hilo.busy), 64'(0));
        issue(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b1);
        check("mtlo_busy", 64'(hilo.busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("mtlo_hold_hi", 64'(hilo.HI_write_data), 64'(32'h1234_5678));

        // Stall behaviour while a divide runs; second start must be dropped
        w0 = n_writes;
        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        hilo.start = 1'b1;
        hilo.op = OP_MULTU;
        hilo.operand_a = 32'd5;
        hilo.operand_b = 32'd6;
        hilo.read_hilo_request = 1'b1;
        #1 check("stall_start_rd", 64'(hilo.stall), 64'(1));
        @(posedge clk); #1;
        hilo.read_hilo_request = 1'b0;
        #1 check("stall_start", 64'(hilo.stall), 64'(1));
        @(posedge clk); #1;
        hilo.start = 1'b0;
        hilo.read_hilo_request = 1'b1;
        #1 check("stall_read", 64'(hilo.stall), 64'(1));
        @(posedge clk); #1;
        hilo.read_hilo_request = 1'b0;
        #1 check("stall_clear", 64'(hilo.stall), 64'(0));
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("div_write_count", 64'(n_writes - w0), 64'(1));
        hilo.read_hilo_request = 1'b1;
        #1 check("stall_idle_read", 64'(hilo.stall), 64'(0));
        hilo.read_hilo_request = 1'b0;

        // Start presented during WRITE is accepted on the following IDLE cycle
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b1);
        repeat (LAT - 1) @(posedge clk);
        #1;
        hilo.start = 1'b1;
        hilo.op = OP_MULTU;
        hilo.operand_a = 32'h0001_0000;
        hilo.operand_b = 32'h0001_0000;
        sb_q.push_back(model(OP_MULTU, 32'h0001_0000, 32'h0001_0000, cyc + 1));
        #1 check("stall_on_write", 64'(hilo.stall), 64'(1));
        @(posedge clk); #1;
        check("idle_after_write", 64'(hilo.busy), 64'(0));
        check("no_stall_idle", 64'(hilo.stall), 64'(0));
        @(posedge clk); #1;
        hilo.start = 1'b0;
        check("retry_accepted", 64'(hilo.busy), 64'(1));
        wait_idle();

        // Reset aborts a divide with no write
        issue(OP_DIV, 32'd12345, 32'd67, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        hilo.read_hilo_request = 1'b1;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(hilo.busy), 64'(0));
        check("abort_stall", 64'(hilo.stall), 64'(0));
        check("abort_hi_data", 64'(hilo.HI_write_data), 64'(0));
        #1;
        reset = 1'b0;
        hilo.read_hilo_request = 1'b0;
        w0 = n_writes;
        repeat (30) @(posedge clk);
        #1;
        check("abort_write_count", 64'(n_writes - w0), 64'(0));

        for (int i = 0; i < 12; i++) begin
            rop = muldiv_op_t'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 1) rb = 32'd0;
            if (i % 4 == 2) ra = 32'h8000_0000;
            if (i % 4 == 3) rb = 32'hFFFF_FFFF;
            issue(rop, ra, rb, 1'b1);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
